// File: rtl/mwd_pkg.sv
// Shared definitions for the post-execution memory word display.
// Holds the controller state encoding, the 7-segment glyph table,
// the blank pattern and the byte stride between consecutive words.
package mwd_pkg;

  typedef enum logic [1:0] {
    MWD_CPU   = 2'd0,
    MWD_FETCH = 2'd1,
    MWD_WAIT  = 2'd2,
    MWD_SHOW  = 2'd3
  } mwd_state_e;

  // Segments are {g,f,e,d,c,b,a}, active-low (0 = lit).
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10, // 9
    7'h08, // A
    7'h03, // b
    7'h46, // C
    7'h21, // d
    7'h06, // E
    7'h0E  // F
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Byte distance between consecutive displayed words.
  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/mem_word_display_btn_sync_edge.sv
// Button conditioner: STAGES-flop synchroniser for an asynchronous level,
// followed by a registered rising-edge detector. pulse_o is high for
// exactly one clk cycle, STAGES+1 cycles after the input rises.
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              last_q;
  logic              last_d;
  logic              pulse_q;
  logic              pulse_d;

  // Shift the raw level through the synchroniser and detect a 0->1 step.
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], btn_i};
    last_d  = sync_q[STAGES-1];
    pulse_d = sync_q[STAGES-1] & ~last_q;
  end

  // Synchroniser, history and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      last_q  <= last_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/mem_word_display.sv
// Post-execution memory inspector. After a "finish" pulse it takes over
// the data-memory read port, fetches one word of a BASE_ADDR-based window
// and shows its low nibbles on a multiplexed 7-segment display. next_i
// steps forward through the window with wrap-around.
// Optional build macro MWD_PREV_EN adds the prev_i port and backward stepping.
//
// Memory port protocol: while mem_owner_o is high this block owns the
// address port; mem_rd_o is high in FETCH and WAIT, mem_addr_o is constant
// from FETCH through SHOW, and mem_rdata_i is sampled READ_LAT cycles after
// the FETCH cycle (in FETCH itself when READ_LAT is 0). There is no
// backpressure: the memory must honour the fixed latency.
module mem_word_display
  import mwd_pkg::*;
#(
  parameter int                DIGITS     = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h0000_0004),
  parameter int                WORD_COUNT = 16,
  parameter int                READ_LAT   = 1,
  parameter int                SCAN_DIV   = 100000,
  localparam int               IDX_W      = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              finish_i,
  input  logic              next_i,
`ifdef MWD_PREV_EN
  input  logic              prev_i,
`endif
  output logic              mem_owner_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [IDX_W-1:0]  index_o,
  output logic [DIGITS-1:0] sel_o,
  output logic [6:0]        seg_o,
  output mwd_state_e        dbg_state_o
);

  localparam int LAT_W = 2;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  logic finish_p;
  logic next_p;
  logic prev_p;

  btn_sync_edge #(.STAGES(2)) u_finish_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (finish_i),
    .pulse_o (finish_p)
  );

  btn_sync_edge #(.STAGES(2)) u_next_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (next_i),
    .pulse_o (next_p)
  );

`ifdef MWD_PREV_EN
  btn_sync_edge #(.STAGES(2)) u_prev_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (prev_i),
    .pulse_o (prev_p)
  );
`else
  assign prev_p = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Controller state
  // ------------------------------------------------------------------
  mwd_state_e        state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic [LAT_W-1:0]  lat_q,   lat_d;
  logic              owner_q, owner_d;
  logic              rd_q,    rd_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  // Next-state logic: fetch sequencing and window stepping.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    word_d  = word_q;
    lat_d   = lat_q;
    case (state_q)
      MWD_CPU: begin
        if (finish_p) begin
          state_d = MWD_FETCH;
          index_d = '0;
        end
      end
      MWD_FETCH: begin
        if (READ_LAT == 0) begin
          word_d  = mem_rdata_i;
          state_d = MWD_SHOW;
        end else begin
          lat_d   = LAT_W'(READ_LAT - 1);
          state_d = MWD_WAIT;
        end
      end
      MWD_WAIT: begin
        if (lat_q == '0) begin
          word_d  = mem_rdata_i;
          state_d = MWD_SHOW;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      MWD_SHOW: begin
        // Simultaneous next and prev cancel each other out.
        if (next_p && !prev_p) begin
          state_d = MWD_FETCH;
          if (index_q == IDX_W'(WORD_COUNT - 1)) index_d = '0;
          else                                   index_d = index_q + IDX_W'(1);
        end else if (prev_p && !next_p) begin
          state_d = MWD_FETCH;
          if (index_q == '0) index_d = IDX_W'(WORD_COUNT - 1);
          else               index_d = index_q - IDX_W'(1);
        end
      end
      default: state_d = MWD_CPU;
    endcase
  end

  // Memory-port outputs, registered from the next state so they line up
  // with the state they describe.
  always_comb begin
    owner_d = (state_d != MWD_CPU);
    rd_d    = (state_d == MWD_FETCH) || (state_d == MWD_WAIT);
    addr_d  = addr_q;
    if (state_d == MWD_FETCH) begin
      addr_d = BASE_ADDR + (ADDR_W'(index_d) * ADDR_W'(WORD_STRIDE));
    end
  end

  // Controller and memory-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MWD_CPU;
      index_q <= '0;
      word_q  <= '0;
      lat_q   <= '0;
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      word_q  <= word_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
    end
  end

  // ------------------------------------------------------------------
  // Display scanner
  // ------------------------------------------------------------------
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [DIGITS-1:0] sel_q,   sel_d;
  logic [6:0]        seg_q,   seg_d;
  logic [3:0]        nibble;

  // Prescaler and digit pointer; they run in every state so the first
  // lit digit appears without a scan gap.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    digit_d = digit_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      if (digit_q == DIG_W'(DIGITS - 1)) digit_d = '0;
      else                               digit_d = digit_q + DIG_W'(1);
    end
  end

  // Digit enable and glyph for the slot being entered.
  always_comb begin
    nibble = word_d[{digit_d, 2'b00} +: 4];
    sel_d  = '1;
    seg_d  = SEG_BLANK;
    if (state_d != MWD_CPU) begin
      sel_d[digit_d] = 1'b0;
      seg_d          = HEX_SEG[nibble];
    end
  end

  // Scanner registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      digit_q <= '0;
      sel_q   <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign mem_owner_o = owner_q;
  assign mem_rd_o    = rd_q;
  assign mem_addr_o  = addr_q;
  assign index_o     = index_q;
  assign sel_o       = sel_q;
  assign seg_o       = seg_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_word_display.sv
// Bench for mem_word_display: reset state, a finish-triggered first fetch,
// a full forward lap of the window, dropped pulses, finish ignored after
// takeover, reset during WAIT, and (with MWD_PREV_EN) backward wrap and
// simultaneous next+prev.
module tb_mem_word_display;
  import mwd_pkg::*;

  localparam int DIGITS     = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WORD_COUNT = 16;
  localparam int READ_LAT   = 1;
  localparam int SCAN_DIV   = 4;
  localparam int IDX_W      = 4;
  localparam int K_FINISH   = 0;
  localparam int K_NEXT     = 1;
  localparam int K_PREV     = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    int          idx;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              finish_i;
  logic              next_i;
`ifdef MWD_PREV_EN
  logic              prev_i;
`endif
  logic              mem_owner_o;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [IDX_W-1:0]  index_o;
  logic [DIGITS-1:0] sel_o;
  logic [6:0]        seg_o;
  mwd_state_e        dbg_state_o;

  int tests = 0;
  int fails = 0;
  int rd_cycles = 0;
  logic [6:0] exp_q[$];
  vec_t vecs[17];

  mem_word_display #(
    .DIGITS     (DIGITS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BASE_ADDR  (32'h0000_0004),
    .WORD_COUNT (WORD_COUNT),
    .READ_LAT   (READ_LAT),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .finish_i    (finish_i),
    .next_i      (next_i),
`ifdef MWD_PREV_EN
    .prev_i      (prev_i),
`endif
    .mem_owner_o (mem_owner_o),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .index_o     (index_o),
    .sel_o       (sel_o),
    .seg_o       (seg_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Memory contents seen by the inspector.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h4) return 32'h0000_1A2B;
    return {8'h00, a[7:0] ^ 8'hC3, a[15:0]};
  endfunction

  // Active-low {g,f,e,d,c,b,a} glyphs.
  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Single-cycle-latency synchronous memory.
  always @(posedge clk) begin
    if (mem_rd_o) mem_rdata_i <= mem_val(mem_addr_o);
  end

  // Count read-enable cycles to detect extra or missing fetches.
  always @(posedge clk) begin
    if (mem_rd_o) rd_cycles <= rd_cycles + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_btn(input int kind, input logic v);
    case (kind)
      K_FINISH: finish_i = v;
      K_NEXT:   next_i = v;
`ifdef MWD_PREV_EN
      K_PREV:   prev_i = v;
`endif
      default:  ;
    endcase
  endtask

  // Scan through all digit slots and compare each glyph.
  task automatic check_display(input string name, input logic [31:0] w);
    int n;
    logic [DIGITS-1:0] want_sel;
    logic [6:0] exp_seg;
    for (int d = 0; d < DIGITS; d++) exp_q.push_back(seg_ref(w[4*d +: 4]));
    for (int d = 0; d < DIGITS; d++) begin
      n = 0;
      want_sel = ~(DIGITS'(1) << d);
      while (sel_o !== want_sel && n < 64) begin
        @(negedge clk);
        n++;
      end
      exp_seg = exp_q.pop_front();
      if (n >= 64) check($sformatf("%s_sel%0d", name, d), sel_o, want_sel);
      check($sformatf("%s_seg%0d", name, d), seg_o, exp_seg);
    end
  endtask

  // Called on the negedge where the button was just raised.
  task automatic fetch_check(input string name, input logic [31:0] exp_addr, input int exp_idx);
    int n;
    int rd_n;
    logic [31:0] a0;
    n = 0;
    rd_n = 0;
    while (mem_rd_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_lat"}, n, 4);
    check({name, "_owner"}, mem_owner_o, 1'b1);
    check({name, "_addr"}, mem_addr_o, exp_addr);
    a0 = mem_addr_o;
    while (mem_rd_o === 1'b1 && rd_n < 20) begin
      @(negedge clk);
      rd_n++;
    end
    check({name, "_rd_cycles"}, rd_n, 1 + READ_LAT);
    check({name, "_addr_held"}, mem_addr_o, a0);
    check({name, "_state"}, dbg_state_o, MWD_SHOW);
    check({name, "_index"}, index_o, exp_idx);
    check_display(name, mem_val(exp_addr));
  endtask

  initial begin
    int snap;
    int n;

    // Vector table: finish, then a full lap of next presses.
    vecs[0] = '{K_FINISH, 32'h4, 0};
    for (int i = 1; i <= 16; i++) begin
      vecs[i] = '{K_NEXT, 32'h4 + 32'(4 * (i % WORD_COUNT)), i % WORD_COUNT};
    end

    // Reset and idle
    reset = 1'b1;
    finish_i = 1'b0;
    next_i = 1'b0;
`ifdef MWD_PREV_EN
    prev_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_owner", mem_owner_o, 1'b0);
    check("idle_rd", mem_rd_o, 1'b0);
    check("idle_addr", mem_addr_o, 32'h0);
    check("idle_sel", sel_o, 4'hF);
    check("idle_seg", seg_o, 7'h7F);
    check("idle_index", index_o, 0);

    // Table-driven fetches
    for (int i = 0; i < 17; i++) begin
      set_btn(vecs[i].kind, 1'b1);
      fetch_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].idx);
      set_btn(vecs[i].kind, 1'b0);
      repeat (4) @(negedge clk);
    end

    // Second next edge timed to arrive during WAIT must be dropped.
    snap = rd_cycles;
    next_i = 1'b1;
    @(negedge clk);
    next_i = 1'b0;
    @(negedge clk);
    next_i = 1'b1;
    repeat (3) @(negedge clk);
    check("drop_in_wait_state", dbg_state_o, MWD_WAIT);
    repeat (8) @(negedge clk);
    check("drop_rd_cycles", rd_cycles - snap, 2);
    check("drop_index", index_o, 1);
    check("drop_addr", mem_addr_o, 32'h8);
    check("drop_state", dbg_state_o, MWD_SHOW);
    next_i = 1'b0;
    repeat (4) @(negedge clk);

    // finish after takeover is ignored.
    snap = rd_cycles;
    finish_i = 1'b1;
    repeat (10) @(negedge clk);
    check("finish_ignored_rd", rd_cycles - snap, 0);
    check("finish_ignored_index", index_o, 1);
    finish_i = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during WAIT releases the port immediately.
    next_i = 1'b1;
    n = 0;
    while (dbg_state_o !== MWD_WAIT && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_wait", dbg_state_o, MWD_WAIT);
    reset = 1'b1;
    #1;
    check("rst_owner", mem_owner_o, 1'b0);
    check("rst_rd", mem_rd_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_sel", sel_o, 4'hF);
    check("rst_seg", seg_o, 7'h7F);
    check("rst_index", index_o, 0);
    next_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    finish_i = 1'b1;
    fetch_check("restart", 32'h4, 0);
    finish_i = 1'b0;
    repeat (4) @(negedge clk);

`ifdef MWD_PREV_EN
    // Backward wrap from index 0.
    prev_i = 1'b1;
    fetch_check("prev_wrap", 32'h40, 15);
    prev_i = 1'b0;
    repeat (4) @(negedge clk);

    // next and prev together cancel.
    snap = rd_cycles;
    next_i = 1'b1;
    prev_i = 1'b1;
    repeat (10) @(negedge clk);
    check("both_rd", rd_cycles - snap, 0);
    check("both_addr", mem_addr_o, 32'h40);
    check("both_index", index_o, 15);
    check("both_state", dbg_state_o, MWD_SHOW);
    next_i = 1'b0;
    prev_i = 1'b0;
    repeat (4) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_word_display.md
# mem_word_display

Post-execution memory inspector for the pipelined CPU board top. After the CPU run finishes, it takes over the data-memory address/read port and fetches one word at a time from a configurable window. It steps through that window on button presses and shows the low nibbles of the current word on an N-digit multiplexed 7-segment display. It replaces the ad-hoc multi-edge display logic with synchronised inputs, an explicit FSM, bounded wrap-around and a parametrised scanner.

## Interface
Parameters:
- DIGITS, 4: number of 7-seg digits, legal range 1..8; the display shows word bits [4*DIGITS-1:0].
- ADDR_W, 32: memory address width.
- DATA_W, 32: memory data width; must be ≥ 4*DIGITS.
- BASE_ADDR, 32'h0000_0004: byte address of the first displayed word.
- WORD_COUNT, 16: number of words in the window, ≥ 1; the index wraps modulo this.
- READ_LAT, 1: cycles from the FETCH state to valid mem_rdata_i, range 0..3.
- SCAN_DIV, 100000: clk cycles per digit slot, ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- finish_i  in  1  asynchronous "execution finished" button/level.
- next_i  in  1  asynchronous "show next word" button.
- prev_i  in  1  asynchronous "show previous word" button; present only with MWD_PREV_EN.
- mem_owner_o  out  1  1 = this block drives the memory address port; the top muxes on it.
- mem_rd_o  out  1  memory read enable.
- mem_addr_o  out  ADDR_W  read byte address.
- mem_rdata_i  in  DATA_W  memory read data.
- index_o  out  clog2(WORD_COUNT) (min 1)  current window index.
- sel_o  out  DIGITS  digit enables, active-low, one-hot when lit.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Each button passes through a 2-flop synchroniser and a rising-edge detector, producing a 1-cycle pulse. finish_i is edge-detected in the same way.
- FSM states and outputs:
  - CPU: owner=0, rd=0, display blank.
  - FETCH: owner=1, rd=1, addr=BASE_ADDR+4*index.
  - WAIT: owner=1, rd=1, addr held.
  - SHOW: owner=1, rd=0, addr held.
- FSM transitions:
  - CPU → FETCH on a finish pulse; index←0.
  - FETCH → WAIT when READ_LAT>0. The latency counter is loaded READ_LAT-1.
  - WAIT → SHOW when the counter is 0; the word is latched from mem_rdata_i on that cycle.
  - FETCH → SHOW directly when READ_LAT=0; mem_rdata_i is latched in FETCH.
  - SHOW + next pulse → FETCH, index←(index+1) mod WORD_COUNT.
  - SHOW + prev pulse → FETCH, index←(index-1) mod WORD_COUNT (only with MWD_PREV_EN).
- Display mode is sticky: there is no return to CPU except via reset.
- Button pulses arriving in FETCH or WAIT are dropped, not queued.
- next and prev pulses in the same SHOW cycle: both are ignored and the state stays SHOW.
- finish pulses outside CPU are ignored.
- Address arithmetic is done in ADDR_W bits and wraps modulo 2^ADDR_W.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1. On terminal count the digit pointer advances modulo DIGITS.
  - Digit d (0 = rightmost) shows hex nibble word[4d+3:4d], decoded to the standard 0-F glyphs.
  - In CPU state, sel_o and seg_o are all-ones (blank). The scanner keeps running so the first lit digit appears without a gap.

## Timing
- Reset values:
  - state CPU, index 0, latched word 0, prescaler 0, digit pointer 0.
  - mem_owner_o 0, mem_rd_o 0, mem_addr_o 0.
  - sel_o all-ones, seg_o 7'h7F.
- Button-to-pulse latency: 3 clk from an async edge (2 sync flops + edge register).
- Pulse to mem_rd_o: the FSM is in FETCH on the cycle after the pulse.
- Pulse to new digits: 1 + READ_LAT + 1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- mem_addr_o is stable for the whole FETCH..SHOW interval.
- Reset asserted mid-FETCH or mid-WAIT: every output takes its reset value immediately (asynchronously), which releases the memory port to the CPU.

## Configuration
- MWD_PREV_EN defined:
  - the prev_i port exists;
  - backward stepping with wrap is active (index 0 → WORD_COUNT-1);
  - the same-cycle next+prev rule applies.
- MWD_PREV_EN undefined:
  - there is no prev_i port and no prev synchroniser logic;
  - only forward stepping is supported.

## Structure
- Package mwd_pkg holds:
  - the state enum (MWD_CPU, MWD_FETCH, MWD_WAIT, MWD_SHOW);
  - a 16-entry hex-to-segment constant table;
  - SEG_BLANK = 7'h7F;
  - the word-stride constant 4.
- Sub-module btn_sync_edge (parameter STAGES=2): synchroniser plus rising-edge pulse. It is instantiated per button and for finish_i.

## Test plan
- Reset, then idle for 100 cycles → owner=0, rd=0, addr=0, sel=4'hF, seg=7'h7F.
- finish pulse, READ_LAT=1, memory returns 32'h0000_1A2B at 0x4 → addr=0x4, rd=1 for 2 cycles, then SHOW. Scanned digits read 1,A,2,b with seg for digit0 = "b" glyph.
- 16 next pulses with WORD_COUNT=16 → addresses 0x8, 0xC, …, 0x40, then back to 0x4; index_o returns to 0.
- next pulse injected during WAIT → dropped: index stays the same and only one fetch occurs.
- MWD_PREV_EN, with index 0 in SHOW: prev pulse → addr=BASE_ADDR+4*15=0x40. Simultaneous next+prev → no fetch, addr unchanged.
- Reset asserted during WAIT → owner drops to 0 in the same cycle. A later finish pulse restarts at addr 0x4.
